// File: rtl/fetch_queue.sv
// Fetch-to-decode instruction queue: a DEPTH-entry FIFO of PC/instruction pairs with branch flush.
// Define FETCH_QUEUE_BYPASS_EN to let an empty queue hand the incoming pair straight to decode.
module fetch_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_instr,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_instr,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   pc_mem_q    [DEPTH];
    logic [31:0]   instr_mem_q [DEPTH];

    logic stored_valid_s;
    logic in_ready_s;
    logic bypass_s;
    logic push_s;
    logic pop_s;

    assign stored_valid_s = (count_q != {CW{1'b0}});
    assign in_ready_s     = (count_q < DEPTH_C);

`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass_s = !stored_valid_s && in_valid && !flush;
`else
    assign bypass_s = 1'b0;
`endif

    // Handshake qualification and pointer/count next state; flush overrides everything.
    always_comb begin
        push_s  = in_valid && in_ready_s && !flush && !(bypass_s && out_ready);
        pop_s   = stored_valid_s && out_ready && !flush;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            head_d  = {AW{1'b0}};
            tail_d  = {AW{1'b0}};
            count_d = {CW{1'b0}};
        end else begin
            if (pop_s) begin
                head_d = head_q + AW'(1);
            end else begin
                head_d = head_q;
            end
            if (push_s) begin
                tail_d = tail_q + AW'(1);
            end else begin
                tail_d = tail_q;
            end
            count_d = count_q + CW'(push_s) - CW'(pop_s);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= {AW{1'b0}};
            tail_q  <= {AW{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is left unreset: entries are only visible once counted as occupied.
    always_ff @(posedge clk) begin
        if (push_s) begin
            pc_mem_q[tail_q]    <= in_pc;
            instr_mem_q[tail_q] <= in_instr;
        end
    end

    // Head presentation; zeros when nothing is available so decode sees a clean bubble.
    always_comb begin
        out_valid = 1'b0;
        out_pc    = 32'd0;
        out_instr = 32'd0;
        if (stored_valid_s) begin
            out_valid = 1'b1;
            out_pc    = pc_mem_q[head_q];
            out_instr = instr_mem_q[head_q];
        end else if (bypass_s) begin
            out_valid = 1'b1;
            out_pc    = in_pc;
            out_instr = in_instr;
        end else begin
            out_valid = 1'b0;
        end
    end

    assign in_ready = in_ready_s;
    assign count    = count_q;

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of entries; a power of two, at least 2.
REQ-002 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset; asynchronous, active-high.
REQ-004 SHALL have port flush  input  1  synchronous discard of all entries (branch taken).
REQ-005 SHALL have port in_valid  input  1  the fetch stage presents a PC/instruction pair.
REQ-006 SHALL have port in_pc  input  32  PC+4 value from the fetch stage.
REQ-007 SHALL have port in_instr  input  32  fetched instruction word.
REQ-008 SHALL have port in_ready  output  1  queue accepts a push; fetch freeze = ~in_ready.
REQ-009 SHALL have port out_valid  output  1  head entry is available to decode.
REQ-010 SHALL have port out_pc  output  32  head entry PC.
REQ-011 SHALL have port out_instr  output  32  head entry instruction.
REQ-012 SHALL have port out_ready  input  1  decode consumes the head entry this cycle.
REQ-013 SHALL have port count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-014 SHALL push an entry when in_valid && in_ready and no flush is active; the entry is written at the tail and the tail pointer increments modulo DEPTH.
REQ-015 SHALL pop an entry when out_valid && out_ready and no flush is active; the head pointer increments modulo DEPTH.
REQ-016 SHALL drive in_ready = (count < DEPTH), derived from registered state only, with no combinational path from out_ready.
REQ-017 SHALL drive out_valid = (count != 0), and drive out_pc/out_instr from the head entry; both SHALL be 32'd0 when the queue is empty.
REQ-018 SHALL, on a simultaneous push and pop, keep count unchanged and advance both pointers.
REQ-019 SHALL, when full, refuse pushes (in_ready=0) even if a pop occurs in the same cycle; in_ready rises in the cycle after the pop.
REQ-020 SHALL, on a pop from an empty queue, take no action: no pointer movement and no count underflow.
REQ-021 SHALL, when flush=1, set count, head and tail to 0 on the next edge and ignore any push or pop in that cycle; in_ready stays 1 during the flush cycle.
REQ-022 SHALL preserve FIFO order: entries leave in push order with pc and instr kept paired.
REQ-023 SHALL give a minimum latency of 1 cycle from push to out_valid when bypass is not compiled in.

Reset
REQ-024 SHALL, on rst=1, immediately force count=0, head=0, tail=0, out_valid=0, out_pc=0, out_instr=0, and in_ready=1, independent of clk.
REQ-025 SHALL NOT reset the storage array contents; they are unobservable while empty.
REQ-026 SHALL, on rst asserted mid-transfer, lose all entries, and the first push after rst deassertion SHALL be the first entry popped.

Configuration
REQ-027 SHALL honour the macro FETCH_QUEUE_BYPASS_EN.
- When defined and count==0 with in_valid=1 and no flush: drive out_valid=1 and out_pc/out_instr=in_pc/in_instr combinationally.
- In that case, if out_ready=1, the pair is consumed without being written and count stays 0; otherwise the pair is written as a normal push.
REQ-028 SHALL, when FETCH_QUEUE_BYPASS_EN is undefined, have no combinational input-to-output path; behaviour is exactly REQ-014 to REQ-023.

Verification
REQ-029 SHALL cover: push pc=4,8,12,16 (instr 0xE0000001..4) with out_ready=0 -> count=4, in_ready=0; then out_ready=1 -> pops in order 4,8,12,16, count back to 0.
REQ-030 SHALL cover: full queue with in_valid=1 and out_ready=1 in the same cycle -> no push that cycle, count=3, in_ready=1 in the next cycle.
REQ-031 SHALL cover: count=3 with flush=1 and in_valid=1 -> next cycle count=0, out_valid=0, out_pc=0; a push of pc=0x100 afterwards is popped first.
REQ-032 SHALL cover: continuous push/pop for 10 cycles (pc=4..40) -> count steady at 1 with no bypass, 0 with bypass; wrap-around ordering correct.
REQ-033 SHALL cover: rst asserted between clock edges with count=2 -> out_valid=0 and count=0 immediately, before the next edge.
REQ-034 SHALL cover, with FETCH_QUEUE_BYPASS_EN defined: empty queue, in_valid=1 with pc=0x20 and out_ready=1 -> out_valid=1 and out_pc=0x20 in the same cycle, count stays 0.
